// File: rtl/adder_arbiter_if.sv
// Request/grant/result bundle between three requesters and the shared-adder arbiter.
// master = requester side, slave = arbiter side.
interface adder_arbiter_if #(
  parameter int WIDTH = 20,
  parameter int CNT_W = 16
);
  logic [2:0]       req;
  logic [WIDTH-1:0] a0, b0;
  logic [WIDTH-1:0] a1, b1;
  logic [WIDTH-1:0] a2, b2;
  logic [2:0]       gnt;
  logic [2:0]       done;
  logic [WIDTH-1:0] sum;
  logic             busy;
  logic [CNT_W-1:0] ops_cnt;

  modport master (
    output req, a0, b0, a1, b1, a2, b2,
    input  gnt, done, sum, busy, ops_cnt
  );

  modport slave (
    input  req, a0, b0, a1, b1, a2, b2,
    output gnt, done, sum, busy, ops_cnt
  );
endinterface

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one 20-bit ripple adder among three requesters.
// Operands and result are registered so the ripple path sits between two flops.

module Full_Adder20 (
  input  logic [19:0] a,
  input  logic [19:0] b,
  output logic [19:0] s
);
  logic [19:0] c;

  assign c[0] = 1'b0;

  // The carry out of bit 19 is never formed: the shared result is modulo 2^20.
  for (genvar i = 0; i < 20; i++) begin : g_bit
    assign s[i] = a[i] ^ b[i] ^ c[i];
    if (i < 19) begin : g_carry
      assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end
endmodule

module adder_arbiter #(
  parameter int WIDTH = 20,
  parameter int CNT_W = 16
) (
  input logic            clk,
  input logic            rst_n,
  adder_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state;
  logic [1:0]       last;
  logic [1:0]       cand1, cand2, winner;
  logic [WIDTH-1:0] op_a, op_b;
  logic [WIDTH-1:0] win_a, win_b;
  logic [WIDTH-1:0] add_s;
  logic [2:0]       gnt_q, done_q;
  logic [WIDTH-1:0] sum_q;
  logic [CNT_W-1:0] ops_cnt_q;

  function automatic logic [1:0] next_idx(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    cand1  = next_idx(last);
    cand2  = next_idx(cand1);
    winner = last;
    if (bus.req[cand1])      winner = cand1;
    else if (bus.req[cand2]) winner = cand2;
  end

  always_comb begin
    win_a = bus.a2;
    win_b = bus.b2;
    case (winner)
      2'd0:    begin win_a = bus.a0; win_b = bus.b0; end
      2'd1:    begin win_a = bus.a1; win_b = bus.b1; end
      default: begin win_a = bus.a2; win_b = bus.b2; end
    endcase
  end

  Full_Adder20 u_adder (
    .a (op_a),
    .b (op_b),
    .s (add_s)
  );

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last      <= 2'd2;
      gnt_q     <= '0;
      done_q    <= '0;
      sum_q     <= '0;
      op_a      <= '0;
      op_b      <= '0;
      ops_cnt_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= '0;
          if (|bus.req) begin
            gnt_q <= 3'b001 << winner;
            op_a  <= win_a;
            op_b  <= win_b;
            last  <= winner;
            state <= EXEC;
          end
        end
        EXEC: begin
          sum_q  <= add_s;
          done_q <= gnt_q;
          state  <= RESP;
        end
        RESP: begin
          done_q    <= '0;
          gnt_q     <= '0;
          ops_cnt_q <= ops_cnt_q + 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.done    = done_q;
  assign bus.sum     = sum_q;
  assign bus.busy    = (state != IDLE);
  assign bus.ops_cnt = ops_cnt_q;
endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter: expected results go into a scoreboard queue when
// requests are driven and are popped when the matching done pulse appears.
module tb_adder_arbiter;
  localparam int CNT_W = 4;

  typedef struct {
    logic [1:0]  idx;
    logic [19:0] s;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  adder_arbiter_if #(.WIDTH(20), .CNT_W(CNT_W)) bus ();

  adder_arbiter #(.WIDTH(20), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t             sb[$];
  int               n_checks = 0;
  int               n_pass   = 0;
  int               cyc      = 0;
  int               last_done_cyc = 0;
  logic [CNT_W-1:0] exp_ops;

  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic push(input int idx, input logic [19:0] a, input logic [19:0] b);
    exp_t e;
    e.idx = idx[1:0];
    e.s   = a + b;
    sb.push_back(e);
  endtask

  task automatic idle_check(input string tag, input logic [19:0] exp_sum);
    check({tag, " gnt/done/busy"}, {bus.gnt, bus.done, bus.busy}, 7'd0);
    check({tag, " sum"}, bus.sum, exp_sum);
    check({tag, " ops_cnt"}, bus.ops_cnt, exp_ops);
  endtask

  // Waits (bounded) for the next done pulse and compares it against the scoreboard head.
  task automatic expect_done(input string tag, input int spacing);
    int   k = 0;
    exp_t e;
    do begin
      @(negedge clk);
      k++;
    end while (bus.done === 3'b000 && k < 20);
    n_checks++;
    assert (bus.done !== 3'b000) n_pass++;
    else $error("FAIL %s timeout: done stayed %b after %0d cycles", tag, bus.done, k);
    if (bus.done === 3'b000) return;
    n_checks++;
    assert (sb.size() > 0) n_pass++;
    else $error("FAIL %s unexpected done: got %b expected no pulse", tag, bus.done);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    check({tag, " done"}, bus.done, 3'b001 << e.idx);
    check({tag, " gnt"}, bus.gnt, 3'b001 << e.idx);
    check({tag, " sum"}, bus.sum, e.s);
    check({tag, " ops_cnt"}, bus.ops_cnt, exp_ops);
    exp_ops = exp_ops + 1'b1;
    if (spacing > 0) check({tag, " spacing"}, cyc - last_done_cyc, spacing);
    last_done_cyc = cyc;
  endtask

  initial begin
    rst_n   = 1'b0;
    bus.req = 3'b000;
    bus.a0 = '0; bus.b0 = '0;
    bus.a1 = '0; bus.b1 = '0;
    bus.a2 = '0; bus.b2 = '0;
    exp_ops = '0;

    // Reset and idle
    repeat (2) @(negedge clk);
    check("reset", {bus.gnt, bus.done, bus.busy, bus.sum, bus.ops_cnt}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle", {bus.gnt, bus.done, bus.busy, bus.sum, bus.ops_cnt}, 32'd0);
    end

    // Single op with carry wrap; operands changed after grant must not matter
    bus.a0 = 20'h00001; bus.b0 = 20'hFFFFF; bus.req = 3'b001;
    push(0, 20'h00001, 20'hFFFFF);
    @(negedge clk);
    bus.req = 3'b000; bus.a0 = 20'h55555; bus.b0 = 20'h12345;
    check("single grant", {bus.gnt, bus.done, bus.busy}, {3'b001, 3'b000, 1'b1});
    expect_done("single", 0);
    @(negedge clk);
    idle_check("single end", 20'h00000);

    // Round-robin from pointer after requester 0
    bus.a1 = 20'h3FFFF; bus.b1 = 20'h00001;
    bus.a2 = 20'h00ABC; bus.b2 = 20'h00100;
    bus.req = 3'b110;
    push(1, 20'h3FFFF, 20'h00001);
    push(2, 20'h00ABC, 20'h00100);
    expect_done("rr req1", 0);
    bus.req = 3'b100;
    expect_done("rr req2", 3);
    bus.req = 3'b000;
    @(negedge clk);
    idle_check("rr end", 20'h00BBC);

    // Contention: all three held high
    bus.a0 = 20'h00001; bus.a1 = 20'h00002; bus.a2 = 20'h00003;
    bus.b0 = 20'h10000; bus.b1 = 20'h10000; bus.b2 = 20'h10000;
    bus.req = 3'b111;
    for (int r = 0; r < 2; r++) begin
      push(0, 20'h00001, 20'h10000);
      push(1, 20'h00002, 20'h10000);
      push(2, 20'h00003, 20'h10000);
    end
    for (int i = 0; i < 6; i++) expect_done("contention", (i == 0) ? 0 : 3);
    bus.req = 3'b000;
    @(negedge clk);
    idle_check("contention end", 20'h10003);

    // Reset during EXEC of requester 2
    bus.a2 = 20'h12345; bus.b2 = 20'h11111; bus.req = 3'b100;
    @(negedge clk);
    check("abort grant", bus.gnt, 3'b100);
    bus.req = 3'b000;
    rst_n   = 1'b0;
    exp_ops = '0;
    #1;
    check("abort reset", {bus.gnt, bus.done, bus.busy, bus.sum, bus.ops_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort no done", {bus.gnt, bus.done}, 6'd0);
    end
    bus.a0 = 20'h00005; bus.b0 = 20'h00006;
    bus.a2 = 20'h00007; bus.b2 = 20'h00008;
    bus.req = 3'b101;
    push(0, 20'h00005, 20'h00006);
    push(2, 20'h00007, 20'h00008);
    expect_done("post reset req0", 0);
    bus.req = 3'b100;
    expect_done("post reset req2", 3);
    bus.req = 3'b000;
    @(negedge clk);
    idle_check("post reset end", 20'h0000F);

    // Counter wrap: 16 back-to-back ops on requester 1 with a fresh counter
    rst_n = 1'b0;
    @(negedge clk);
    rst_n   = 1'b1;
    exp_ops = '0;
    for (int k = 0; k < 16; k++) push(1, 20'(k * 4097), 20'(20'hFFFF0 + k));
    bus.a1 = 20'(0); bus.b1 = 20'hFFFF0;
    bus.req = 3'b010;
    for (int k = 0; k < 16; k++) begin
      expect_done("wrap", (k == 0) ? 0 : 3);
      bus.a1 = 20'((k + 1) * 4097);
      bus.b1 = 20'(20'hFFFF0 + k + 1);
      if (k == 15) bus.req = 3'b000;
    end
    @(negedge clk);
    idle_check("wrap end", 20'(15 * 4097 + 20'hFFFF0 + 15));
    check("scoreboard empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/adder_arbiter.md
Name: adder_arbiter

Overview:
- Shares one 20-bit ripple adder (Full_Adder20, instantiated inside this block) among three requesters.
- Round-robin arbitration with a req/gnt/done handshake.
- Operands are registered before the adder; the result is registered after it, so ripple delay stays off the request paths.
- Sits between the datapath units that need occasional 20-bit additions (address/PC update, ALU helper) and the single shared adder.

Parameters:
- WIDTH, 20, operand/result width; fixed to 20 to match Full_Adder20, not to be overridden.
- CNT_W, 16, width of the completed-operation counter ops_cnt.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req  input  3  per-requester request; req[i] high in an IDLE cycle means a new request.
- a0, b0  input  20 each  operands of requester 0.
- a1, b1  input  20 each  operands of requester 1.
- a2, b2  input  20 each  operands of requester 2.
- gnt  output  3  one-hot grant; high while requester i owns the adder.
- done  output  3  one-hot, one-cycle pulse; sum is valid for requester i.
- sum  output  20  registered result of the last operation; held until the next result.
- busy  output  1  high in EXEC and RESP.
- ops_cnt  output  CNT_W  count of completed operations; wraps modulo 2^CNT_W.

Behaviour:
- Reset (asynchronous, rst_n low): state=IDLE, gnt=0, done=0, sum=0, busy=0, ops_cnt=0, operand regs=0, rr pointer last=2 (requester 0 has first priority). Takes effect immediately, including mid-operation: no done is issued for an aborted operation.
- States: IDLE, EXEC, RESP, all registered.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise pick the winner by round-robin, searching last+1, last+2, last+3 (mod 3).
  - At the edge: gnt<=onehot(winner), op_a/op_b<=a/b of the winner, last<=winner, state<=EXEC.
- EXEC: adder inputs are op_a/op_b (a full cycle for the ripple to settle). At the edge: sum<=adder s, done<=gnt, state<=RESP.
- RESP: done and gnt high for this single cycle. At the edge: done<=0, gnt<=0, ops_cnt<=ops_cnt+1, state<=IDLE.
- Timing: request sampled at edge E0; gnt high E0..E2; done high E1..E2; sum valid from E1 and held after.
- Throughput: one operation per 3 cycles. No arbitration happens in EXEC or RESP.
- Operand sampling: operands are sampled only at the grant edge; requesters may change a/b afterwards.
- Arithmetic: sum = (op_a + op_b) mod 2^20. Carry-out is discarded and there is no overflow flag. Unsigned and two's-complement results are identical.
- Request drop after grant: if req[i] falls during EXEC or RESP, the operation still completes and done[i] still pulses (no abort).
- Single-operation requesters must have req low in the IDLE cycle following their done. A req still high there is a new request.
- Requests arriving during EXEC/RESP are not lost; they are seen in the next IDLE cycle.
- Simultaneous requests are resolved purely by the rr pointer. No requester waits more than two other operations (starvation-free).
- busy = (state != IDLE).
- gnt and done are always zero or one-hot; done is never high without the matching gnt.

Test Plan:
- Reset/idle: rst_n low then high with req=0 for 10 cycles -> gnt=0, done=0, sum=0, busy=0, ops_cnt=0 throughout.
- Single op with wrap: req[0]=1 with a0=0x00001, b0=0xFFFFF for one cycle, then dropped.
  - gnt=001 for 2 cycles; done=001 one cycle after grant.
  - sum=0x00000 (carry dropped); ops_cnt=1; back to IDLE.
- Contention: req=111 held continuously with a_i=i+1, b_i=0x10000.
  - Grants in order 0,1,2,0,1,2, each 3 cycles apart.
  - sum sequence 0x10001, 0x10002, 0x10003.
- Round-robin from pointer: after an op by requester 0, assert req=110 together.
  - Requester 1 is granted first (0x3FFFF+0x00001 -> sum 0x40000), then requester 2.
- Reset mid-operation: pull rst_n low during EXEC of requester 2 (0x12345+0x11111).
  - No done pulse; sum=0, gnt=0, ops_cnt=0.
  - Next req=101 grants requester 0 first.
- Counter wrap with CNT_W=4: 16 back-to-back ops on requester 1 -> ops_cnt counts 1..15 then returns to 0; gnt/done sequencing is unaffected.
